rptr_empty: RTL and testbench
=============================

RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, giving log2 of FIFO depth (depth = 2^ADDRSIZE).
REQ-002 SHALL have parameter AEMPTY_THRESH, default 2, giving the almost-empty level in entries.
REQ-003 SHALL have port r_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port r_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port r_inc  input  1  read request for one entry this cycle.
REQ-006 SHALL have port s_rd_ptr  input  ADDRSIZE+1  Gray-coded write pointer, already synchronized into r_clk.
REQ-007 SHALL have port r_underflow_clr  input  1  clears the sticky underflow flag.
REQ-008 SHALL have port r_addr  output  ADDRSIZE  memory read address.
REQ-009 SHALL have port rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain.
REQ-010 SHALL have port r_empty  output  1  FIFO empty flag.
REQ-011 SHALL have port r_aempty  output  1  almost-empty flag.
REQ-012 SHALL have port r_count  output  ADDRSIZE+1  occupancy seen from the read domain.
REQ-013 SHALL have port r_underflow  output  1  sticky flag: a read was attempted while empty.

Function
REQ-014 SHALL hold an internal binary read pointer rbin, ADDRSIZE+1 bits, that wraps modulo 2^(ADDRSIZE+1).
REQ-015 SHALL compute rd_en = r_inc AND NOT r_empty, and rbinnext = rbin + rd_en.
REQ-016 SHALL compute rgraynext = (rbinnext >> 1) XOR rbinnext, and register it into rptr on each edge, so rptr always equals the Gray code of rbin.
REQ-017 SHALL drive r_addr = rbin[ADDRSIZE-1:0] straight from the register, with no extra logic after it.
REQ-018 SHALL register r_empty <= (rgraynext == s_rd_ptr), so a read or a write-pointer change is reflected one cycle later.
REQ-019 SHALL convert s_rd_ptr to binary wbin_s using prefix XOR starting at the MSB.
REQ-020 SHALL register r_count <= (wbin_s - rbinnext) mod 2^(ADDRSIZE+1); values range 0..2^ADDRSIZE.
REQ-021 SHALL register r_aempty <= (next r_count <= AEMPTY_THRESH), using the same next-count value as REQ-020.
REQ-022 SHALL ignore r_inc while r_empty=1: rbin, rptr and r_addr stay unchanged.
REQ-023 SHALL set r_underflow on any cycle with r_inc=1 and r_empty=1.
REQ-024 SHALL clear r_underflow when r_underflow_clr=1; if set and clear occur in the same cycle, set wins.
REQ-025 SHALL wrap rbin from 2^(ADDRSIZE+1)-1 to 0 with no special handling; r_count and r_empty stay correct across the wrap.
REQ-026 SHALL handle a read and a write-pointer change in the same cycle by using both in the REQ-018 and REQ-020 computations for that edge.
REQ-027 SHALL contain no combinational path from s_rd_ptr or r_inc to any output.

Reset
REQ-028 SHALL, on a cycle with r_rst=1, load rbin=0, rptr=0, r_empty=1, r_aempty=1, r_count=0 and r_underflow=0.
REQ-029 SHALL give r_rst priority over r_inc, r_underflow_clr and every s_rd_ptr change, including when asserted in the middle of a read burst.

Verification (ADDRSIZE=4, AEMPTY_THRESH=2)
REQ-030 SHALL check: reset with s_rd_ptr=00000 -> r_empty=1, r_aempty=1, r_count=0, r_addr=0, rptr=00000.
REQ-031 SHALL check: s_rd_ptr=00010 (binary 3), r_inc=0 -> next cycle r_empty=0, r_count=3, r_aempty=0.
REQ-032 SHALL check: from the REQ-031 state, pulse r_inc for 1 cycle -> next cycle r_addr=1, rptr=00001, r_count=2, r_aempty=1; 2 further reads -> r_empty=1, rptr=00010.
REQ-033 SHALL check: r_inc=1 while empty -> rptr unchanged, r_underflow=1 held until r_underflow_clr; clear and set in the same cycle -> r_underflow stays 1.
REQ-034 SHALL check: s_rd_ptr=11000 (binary 16) from reset -> r_count=16, r_aempty=0; read 32 entries while advancing s_rd_ptr -> rbin wraps 31->0, rptr goes 10000->00000, and r_count is correct throughout.
REQ-035 SHALL check: r_rst asserted with rbin=5 and r_inc=1 -> next edge r_addr=0, rptr=00000, r_empty=1, r_count=0.

Source files
------------

// File: rtl/rptr_empty.sv
// rtl/rptr_empty.sv - FIFO read-domain pointer, empty/almost-empty flags, occupancy and sticky underflow.
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                r_inc,
  input  logic [ADDRSIZE:0]   s_rd_ptr,
  input  logic                r_underflow_clr,
  output logic [ADDRSIZE-1:0] r_addr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                r_empty,
  output logic                r_aempty,
  output logic [ADDRSIZE:0]   r_count,
  output logic                r_underflow
);

  localparam logic [ADDRSIZE:0] AEMPTY_LVL = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic              r_empty_q, r_empty_d;
  logic              r_aempty_q, r_aempty_d;
  logic [ADDRSIZE:0] r_count_q, r_count_d;
  logic              r_underflow_q, r_underflow_d;

  logic              rd_en;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] count_next;

  always_comb begin
    rd_en     = r_inc & ~r_empty_q;
    rbinnext  = rbin_q + {{ADDRSIZE{1'b0}}, rd_en};
    rgraynext = (rbinnext >> 1) ^ rbinnext;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(s_rd_ptr >> i);
    end

    count_next = wbin_s - rbinnext;

    rbin_d     = rbinnext;
    rptr_d     = rgraynext;
    r_empty_d  = (rgraynext == s_rd_ptr);
    r_count_d  = count_next;
    r_aempty_d = (count_next <= AEMPTY_LVL);

    // A new underflow outranks a clear landing in the same cycle.
    r_underflow_d = r_underflow_q;
    if (r_underflow_clr) r_underflow_d = 1'b0;
    if (r_inc && r_empty_q) r_underflow_d = 1'b1;
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin_q        <= '0;
      rptr_q        <= '0;
      r_empty_q     <= 1'b1;
      r_aempty_q    <= 1'b1;
      r_count_q     <= '0;
      r_underflow_q <= 1'b0;
    end else begin
      rbin_q        <= rbin_d;
      rptr_q        <= rptr_d;
      r_empty_q     <= r_empty_d;
      r_aempty_q    <= r_aempty_d;
      r_count_q     <= r_count_d;
      r_underflow_q <= r_underflow_d;
    end
  end

  assign r_addr      = rbin_q[ADDRSIZE-1:0];
  assign rptr        = rptr_q;
  assign r_empty     = r_empty_q;
  assign r_aempty    = r_aempty_q;
  assign r_count     = r_count_q;
  assign r_underflow = r_underflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
// tb/tb_rptr_empty.sv - directed vector bench for rptr_empty.
module tb_rptr_empty;

  localparam int ADDRSIZE      = 4;
  localparam int AEMPTY_THRESH = 2;

  logic       r_clk = 1'b0;
  logic       r_rst, r_inc, r_underflow_clr;
  logic [4:0] s_rd_ptr;
  logic [3:0] r_addr;
  logic [4:0] rptr;
  logic       r_empty, r_aempty, r_underflow;
  logic [4:0] r_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 r_clk = ~r_clk;

  rptr_empty #(.ADDRSIZE(ADDRSIZE), .AEMPTY_THRESH(AEMPTY_THRESH)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .r_inc(r_inc), .s_rd_ptr(s_rd_ptr),
    .r_underflow_clr(r_underflow_clr), .r_addr(r_addr), .rptr(rptr),
    .r_empty(r_empty), .r_aempty(r_aempty), .r_count(r_count), .r_underflow(r_underflow)
  );

  typedef struct {
    logic       rst;
    logic       inc;
    logic       clr;
    logic [4:0] s;
    logic [3:0] addr;
    logic [4:0] rptr;
    logic       empty;
    logic       aempty;
    logic [4:0] count;
    logic       uf;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step(input logic rst, input logic inc, input logic clr, input logic [4:0] s);
    r_rst = rst; r_inc = inc; r_underflow_clr = clr; s_rd_ptr = s;
    @(posedge r_clk);
    #1;
  endtask

  task automatic check_outs(input string name, input int idx, input logic [3:0] e_addr,
                            input logic [4:0] e_rptr, input logic e_empty, input logic e_aempty,
                            input logic [4:0] e_count, input logic e_uf);
    logic [16:0] act, exp;
    act = {r_addr, rptr, r_empty, r_aempty, r_count, r_underflow};
    exp = {e_addr, e_rptr, e_empty, e_aempty, e_count, e_uf};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got addr=%0d rptr=%b empty=%b aempty=%b count=%0d uf=%b, expected addr=%0d rptr=%b empty=%b aempty=%b count=%0d uf=%b",
                  name, idx, r_addr, rptr, r_empty, r_aempty, r_count, r_underflow,
                  e_addr, e_rptr, e_empty, e_aempty, e_count, e_uf);
  endtask

  initial begin
    logic [4:0] wb, rb, cnt;
    logic       e;

    r_rst = 1'b1; r_inc = 1'b0; r_underflow_clr = 1'b0; s_rd_ptr = '0;

    //           rst   inc   clr   s         addr rptr      emp   aemp  cnt uf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'b00010, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd3, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'b00010, 4'd1, 5'b00001, 1'b0, 1'b1, 5'd2, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'b00010, 4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 5'b00111, 4'd3, 5'b00010, 1'b0, 1'b1, 5'd2, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 5'b00101, 4'd4, 5'b00110, 1'b0, 1'b1, 5'd2, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 5'b00101, 4'd5, 5'b00111, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 5'b00101, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 5'b00101, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd6, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].inc, vecs[i].clr, vecs[i].s);
      check_outs("vec", i, vecs[i].addr, vecs[i].rptr, vecs[i].empty,
                 vecs[i].aempty, vecs[i].count, vecs[i].uf);
    end

    // Full FIFO, then 32 reads with writes on every other cycle: wraps rbin and drains to empty.
    step(1'b1, 1'b0, 1'b0, 5'b11000);
    check_outs("wrap_reset", 0, 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'b11000);
    check_outs("wrap_full", 0, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd16, 1'b0);

    wb = 5'd16; rb = 5'd0; e = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0) wb = wb + 5'd1;
      step(1'b0, 1'b1, 1'b0, gray(wb));
      if (!e) rb = rb + 5'd1;
      cnt = wb - rb;
      e   = (cnt == 5'd0);
      check_outs("wrap", k, rb[3:0], gray(rb), e, (cnt <= 5'd2), cnt, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
